dmac_li_gen2: RTL and testbench

Parametrised linked-list (LI) DMA channel engine, successor to the single-mode GPU ordering-table channel.
- Walks a chain of packets in main memory and streams each payload through an internal FIFO to a fixed peripheral data port.
- Splits payloads into bursts of bounded length and skips empty packets.
- Detects runaway (looping) lists.
- Supports a clean abort.
- Sits between the DMA register block and the bus master arbiter.

---
 rtl/dmac_pkg.sv | 29 ++
 rtl/dmac_li_gen2_fifo.sv | 46 ++++
 rtl/dmac_li_gen2.sv | 198 +++++++++++++++++++
 tb/tb_dmac_li_gen2.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// Shared state encoding, header layout and port constants for the linked-list DMA channel.
package dmac_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HDR_RD   = 4'd1,
        ST_CHK      = 4'd2,
        ST_PAY_RD   = 4'd3,
        ST_WAIT_REQ = 4'd4,
        ST_PAY_WR   = 4'd5,
        ST_DONE     = 4'd6,
        ST_ERR      = 4'd7,
        ST_ABORT    = 4'd8
    } dmacState_e;

    localparam int HDR_CNT_MSB = 31;
    localparam int HDR_CNT_LSB = 24;
    localparam int HDR_NXT_MSB = 23;
    localparam int HDR_NXT_LSB = 0;

    localparam logic [23:0] END_MARK_DEF  = 24'hFF_FFFF;
    localparam logic [31:0] GPU_DATA_ADDR = 32'h1F80_1810;
    localparam logic [1:0]  BUS_SIZE_WORD = 2'b10;

    function automatic logic [7:0] minBurst(input logic [7:0] remWords, input logic [7:0] maxWords);
        return (remWords < maxWords) ? remWords : maxWords;
    endfunction

endpackage

// File: rtl/dmac_li_gen2_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is on DOUT whenever LEVEL is non-zero.
module SYNC_FIFO #(
    parameter int DEPTH_P2 = 4,
    parameter int WIDTH    = 32
) (
    input  logic                CLK,
    input  logic                RST_SYNC,
    input  logic                EN,
    input  logic                PUSH,
    input  logic [WIDTH-1:0]    DIN,
    input  logic                POP,
    output logic [WIDTH-1:0]    DOUT,
    output logic [DEPTH_P2:0]   LEVEL
);
    localparam logic [DEPTH_P2-1:0] PTR_ONE = DEPTH_P2'(1);
    localparam logic [DEPTH_P2:0]   LVL_ONE = (DEPTH_P2 + 1)'(1);

    logic [WIDTH-1:0]    mem [0:(2**DEPTH_P2)-1];
    logic [DEPTH_P2-1:0] wrPtr;
    logic [DEPTH_P2-1:0] rdPtr;

    always_ff @(posedge CLK) begin
        if (EN && PUSH) begin
            mem[wrPtr] <= DIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            wrPtr <= '0;
            rdPtr <= '0;
            LEVEL <= '0;
        end else if (EN) begin
            if (PUSH) wrPtr <= wrPtr + PTR_ONE;
            if (POP)  rdPtr <= rdPtr + PTR_ONE;
            case ({PUSH, POP})
                2'b10:   LEVEL <= LEVEL + LVL_ONE;
                2'b01:   LEVEL <= LEVEL - LVL_ONE;
                default: ;
            endcase
        end
    end

    assign DOUT = mem[rdPtr];

endmodule

// File: rtl/dmac_li_gen2.sv
// Linked-list DMA channel: walks header chains in memory and streams each payload
// through a local FIFO to a fixed, non-incrementing peripheral data port.
module dmac_li_gen2
    import dmac_pkg::*;
#(
    parameter int          FIFO_DEPTH_P2 = 4,
    parameter int          MAX_BURST     = 16,
    parameter int          LEN_W         = 5,
    parameter int          MAX_NODES     = 4096,
    parameter logic [31:0] DEST_ADDR     = GPU_DATA_ADDR,
    parameter logic [23:0] END_MARK      = END_MARK_DEF
) (
    input  logic                     CLK,
    input  logic                     RST_SYNC,
    input  logic                     EN,
    input  logic                     CFG_DMA_CHCR_TR_IN,
    input  logic                     CFG_DMA_CHCR_LI_IN,
    input  logic [31:0]              CFG_DMA_MADR_IN,
    output logic                     CFG_DMA_CHCR_TR_CLR_OUT,
    output logic                     STATUS_ERR_OUT,
    output logic                     STATUS_ABORT_OUT,
    output logic                     BUS_READ_REQ_OUT,
    input  logic                     BUS_READ_ACK_IN,
    output logic                     BUS_WRITE_REQ_OUT,
    input  logic                     BUS_WRITE_ACK_IN,
    input  logic                     BUS_LAST_ACK_IN,
    output logic [31:0]              BUS_START_ADDR_OUT,
    output logic [1:0]               BUS_SIZE_OUT,
    output logic [LEN_W-1:0]         BUS_LEN_OUT,
    output logic                     BUS_BURST_ADDR_INC_OUT,
    output logic [31:0]              BUS_WRITE_DATA_OUT,
    input  logic [31:0]              BUS_READ_DATA_IN,
    input  logic                     DMAC_REQ_IN,
    output logic                     DMAC_ACK_OUT,
    output logic                     DMAC_IRQ_OUT,
    output dmacState_e               DBG_STATE_OUT,
    output logic [FIFO_DEPTH_P2:0]   DBG_FIFO_LEVEL_OUT
);
    localparam int NODE_W = $clog2(MAX_NODES + 1);

    dmacState_e        state, stateNxt;
    logic [21:0]       wordAddr;
    logic [7:0]        remCnt;
    logic [NODE_W-1:0] nodeCnt;
    logic [23:0]       nxtPtr;
    logic [LEN_W-1:0]  burstLen;
    logic              fifoPush, fifoPop;
    logic              unusedMadr;

    assign unusedMadr = ^{CFG_DMA_MADR_IN[31:24], CFG_DMA_MADR_IN[1:0]};

    // Bus handshake: address/len/inc are registered one cycle before REQ rises; REQ then
    // holds until the beat flagged by LAST_ACK and drops on the next edge. Every ACK seen
    // while REQ is high is one beat, including the one that carries LAST_ACK.
    always_ff @(posedge CLK) begin
        if (RST_SYNC)  state <= ST_IDLE;
        else if (EN)   state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            ST_IDLE:     if (CFG_DMA_CHCR_TR_IN && CFG_DMA_CHCR_LI_IN) stateNxt = ST_HDR_RD;
            ST_HDR_RD:   if (BUS_READ_REQ_OUT && BUS_LAST_ACK_IN) stateNxt = ST_CHK;
            ST_CHK: begin
                if (!CFG_DMA_CHCR_TR_IN)                                       stateNxt = ST_ABORT;
                else if (nodeCnt == NODE_W'(MAX_NODES) && nxtPtr != END_MARK) stateNxt = ST_ERR;
                else if (remCnt == 8'd0 && nxtPtr == END_MARK)                stateNxt = ST_DONE;
                else if (remCnt == 8'd0)                                       stateNxt = ST_HDR_RD;
                else                                                           stateNxt = ST_PAY_RD;
            end
            ST_PAY_RD:   if (BUS_READ_REQ_OUT && BUS_LAST_ACK_IN) stateNxt = ST_WAIT_REQ;
            ST_WAIT_REQ: if (DMAC_REQ_IN) stateNxt = ST_PAY_WR;
            ST_PAY_WR:   if (BUS_WRITE_REQ_OUT && BUS_LAST_ACK_IN) stateNxt = ST_CHK;
            default:     stateNxt = ST_IDLE;
        endcase
    end

    always_comb begin
        DMAC_ACK_OUT            = 1'b0;
        DMAC_IRQ_OUT            = 1'b0;
        CFG_DMA_CHCR_TR_CLR_OUT = 1'b0;
        case (state)
            ST_DONE: begin
                DMAC_ACK_OUT            = 1'b1;
                DMAC_IRQ_OUT            = 1'b1;
                CFG_DMA_CHCR_TR_CLR_OUT = 1'b1;
            end
            ST_ERR, ST_ABORT: begin
                DMAC_IRQ_OUT            = 1'b1;
                CFG_DMA_CHCR_TR_CLR_OUT = 1'b1;
            end
            default: ;
        endcase
        // Header beats never enter the FIFO; only payload reads do.
        fifoPush = BUS_READ_REQ_OUT && BUS_READ_ACK_IN && (state == ST_PAY_RD);
        fifoPop  = BUS_WRITE_REQ_OUT && BUS_WRITE_ACK_IN;
    end

    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            wordAddr               <= '0;
            remCnt                 <= '0;
            nodeCnt                <= '0;
            nxtPtr                 <= '0;
            burstLen               <= '0;
            BUS_READ_REQ_OUT       <= 1'b0;
            BUS_WRITE_REQ_OUT      <= 1'b0;
            BUS_START_ADDR_OUT     <= '0;
            BUS_LEN_OUT            <= '0;
            BUS_BURST_ADDR_INC_OUT <= 1'b0;
            STATUS_ERR_OUT         <= 1'b0;
            STATUS_ABORT_OUT       <= 1'b0;
        end else if (EN) begin
            case (state)
                ST_IDLE: if (stateNxt == ST_HDR_RD) begin
                    wordAddr               <= CFG_DMA_MADR_IN[23:2];
                    nodeCnt                <= '0;
                    STATUS_ERR_OUT         <= 1'b0;
                    STATUS_ABORT_OUT       <= 1'b0;
                    BUS_START_ADDR_OUT     <= {8'h00, CFG_DMA_MADR_IN[23:2], 2'b00};
                    BUS_LEN_OUT            <= LEN_W'(1);
                    BUS_BURST_ADDR_INC_OUT <= 1'b1;
                end
                ST_HDR_RD: begin
                    if (!BUS_READ_REQ_OUT) begin
                        BUS_READ_REQ_OUT <= 1'b1;
                    end else if (BUS_LAST_ACK_IN) begin
                        BUS_READ_REQ_OUT <= 1'b0;
                        remCnt           <= BUS_READ_DATA_IN[HDR_CNT_MSB:HDR_CNT_LSB];
                        nxtPtr           <= BUS_READ_DATA_IN[HDR_NXT_MSB:HDR_NXT_LSB];
                        nodeCnt          <= nodeCnt + NODE_W'(1);
                        wordAddr         <= wordAddr + 22'd1;
                    end
                end
                ST_CHK: begin
                    case (stateNxt)
                        ST_HDR_RD: begin
                            wordAddr               <= nxtPtr[23:2];
                            BUS_START_ADDR_OUT     <= {8'h00, nxtPtr[23:2], 2'b00};
                            BUS_LEN_OUT            <= LEN_W'(1);
                            BUS_BURST_ADDR_INC_OUT <= 1'b1;
                        end
                        ST_PAY_RD: begin
                            burstLen               <= LEN_W'(minBurst(remCnt, 8'(MAX_BURST)));
                            BUS_START_ADDR_OUT     <= {8'h00, wordAddr, 2'b00};
                            BUS_LEN_OUT            <= LEN_W'(minBurst(remCnt, 8'(MAX_BURST)));
                            BUS_BURST_ADDR_INC_OUT <= 1'b1;
                        end
                        ST_ERR:   STATUS_ERR_OUT   <= 1'b1;
                        ST_ABORT: STATUS_ABORT_OUT <= 1'b1;
                        default: ;
                    endcase
                end
                ST_PAY_RD: begin
                    if (!BUS_READ_REQ_OUT) begin
                        BUS_READ_REQ_OUT <= 1'b1;
                    end else if (BUS_LAST_ACK_IN) begin
                        BUS_READ_REQ_OUT <= 1'b0;
                        wordAddr         <= wordAddr + 22'(burstLen);
                    end
                end
                ST_WAIT_REQ: if (DMAC_REQ_IN) begin
                    BUS_START_ADDR_OUT     <= DEST_ADDR;
                    BUS_LEN_OUT            <= burstLen;
                    BUS_BURST_ADDR_INC_OUT <= 1'b0;
                end
                ST_PAY_WR: begin
                    if (!BUS_WRITE_REQ_OUT) begin
                        BUS_WRITE_REQ_OUT <= 1'b1;
                    end else if (BUS_LAST_ACK_IN) begin
                        BUS_WRITE_REQ_OUT <= 1'b0;
                        remCnt            <= remCnt - 8'(burstLen);
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUS_SIZE_OUT  = BUS_SIZE_WORD;
    assign DBG_STATE_OUT = state;

    SYNC_FIFO #(
        .DEPTH_P2 (FIFO_DEPTH_P2),
        .WIDTH    (32)
    ) payloadFifo (
        .CLK      (CLK),
        .RST_SYNC (RST_SYNC),
        .EN       (EN),
        .PUSH     (fifoPush),
        .DIN      (BUS_READ_DATA_IN),
        .POP      (fifoPop),
        .DOUT     (BUS_WRITE_DATA_OUT),
        .LEVEL    (DBG_FIFO_LEVEL_OUT)
    );

endmodule

// File: tb/tb_dmac_li_gen2.sv
// Bench for dmac_li_gen2: memory-backed bus slave, list-walking reference model and per-cycle compare.
module tb_dmac_li_gen2;
    import dmac_pkg::*;

    localparam int          MAXN      = 4;
    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] DEST      = 32'h1F80_1810;
    localparam logic [23:0] ENDM      = 24'hFF_FFFF;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        tr = 1'b0;
    logic        li = 1'b1;
    logic [31:0] madr = '0;
    logic        rd_ack = 1'b0, wr_ack = 1'b0, last_ack = 1'b0;
    logic [31:0] rd_data = '0;
    logic        dmac_req = 1'b1;

    logic        tr_clr, st_err, st_abort, rd_req, wr_req, bus_inc, dmac_ack, dmac_irq;
    logic [31:0] bus_addr, wdata;
    logic [1:0]  bus_size;
    logic [4:0]  bus_len;
    dmacState_e  dbg_state;
    logic [4:0]  fifo_level;

    always #5 clk = ~clk;

    dmac_li_gen2 #(
        .FIFO_DEPTH_P2 (4),
        .MAX_BURST     (16),
        .LEN_W         (5),
        .MAX_NODES     (MAXN),
        .DEST_ADDR     (DEST),
        .END_MARK      (ENDM)
    ) dut (
        .CLK                     (clk),
        .RST_SYNC                (rst),
        .EN                      (en),
        .CFG_DMA_CHCR_TR_IN      (tr),
        .CFG_DMA_CHCR_LI_IN      (li),
        .CFG_DMA_MADR_IN         (madr),
        .CFG_DMA_CHCR_TR_CLR_OUT (tr_clr),
        .STATUS_ERR_OUT          (st_err),
        .STATUS_ABORT_OUT        (st_abort),
        .BUS_READ_REQ_OUT        (rd_req),
        .BUS_READ_ACK_IN         (rd_ack),
        .BUS_WRITE_REQ_OUT       (wr_req),
        .BUS_WRITE_ACK_IN        (wr_ack),
        .BUS_LAST_ACK_IN         (last_ack),
        .BUS_START_ADDR_OUT      (bus_addr),
        .BUS_SIZE_OUT            (bus_size),
        .BUS_LEN_OUT             (bus_len),
        .BUS_BURST_ADDR_INC_OUT  (bus_inc),
        .BUS_WRITE_DATA_OUT      (wdata),
        .BUS_READ_DATA_IN        (rd_data),
        .DMAC_REQ_IN             (dmac_req),
        .DMAC_ACK_OUT            (dmac_ack),
        .DMAC_IRQ_OUT            (dmac_irq),
        .DBG_STATE_OUT           (dbg_state),
        .DBG_FIFO_LEVEL_OUT      (fifo_level)
    );

    // ---------------- shared bench state ----------------
    logic [31:0] mem [0:MEM_WORDS-1];
    burst_t      exp_bursts[$];
    logic [31:0] exp_q[$];
    int          exp_outcome = 0;   // 0 done, 1 node-limit error, 2 abort
    burst_t      got_bursts[$];
    logic [31:0] got_q[$];
    int          irq_cnt = 0, ack_cnt = 0;
    int          n_cmp = 0, n_bad = 0;
    bit          stall_en = 1'b0;

    function automatic int idx(input logic [31:0] word_addr);
        return int'(word_addr % MEM_WORDS);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: walk the list from the header rules ----------------
    task automatic build_model(input logic [31:0] start);
        logic [21:0] a;
        logic [31:0] h;
        logic [23:0] nxt;
        int          nodes, n, k;
        burst_t      b;
        exp_bursts.delete();
        exp_q.delete();
        a     = start[23:2];
        nodes = 0;
        forever begin
            b = '{wr: 1'b0, addr: {8'h00, a, 2'b00}, len: 8'd1};
            exp_bursts.push_back(b);
            h   = mem[idx({10'd0, a})];
            a   = a + 22'd1;
            nodes++;
            n   = int'(h[31:24]);
            nxt = h[23:0];
            forever begin
                if (nodes == MAXN && nxt != ENDM) begin
                    exp_outcome = 1;
                    return;
                end
                if (n == 0) break;
                k = (n < 16) ? n : 16;
                b = '{wr: 1'b0, addr: {8'h00, a, 2'b00}, len: 8'(k)};
                exp_bursts.push_back(b);
                for (int i = 0; i < k; i++) exp_q.push_back(mem[idx({10'd0, a} + 32'(i))]);
                b = '{wr: 1'b1, addr: DEST, len: 8'(k)};
                exp_bursts.push_back(b);
                a = a + 22'(k);
                n = n - k;
            end
            if (nxt == ENDM) begin
                exp_outcome = 0;
                return;
            end
            a = nxt[23:2];
        end
    endtask

    // ---------------- bus slave: memory reads, write sink, optional stalls ----------------
    int beat = 0;
    int stall_ctr = 0;
    always @(negedge clk) begin
        rd_ack   = 1'b0;
        wr_ack   = 1'b0;
        last_ack = 1'b0;
        if (!rd_req && !wr_req) begin
            beat = 0;
        end else if (beat < int'(bus_len)) begin
            stall_ctr++;
            if (!(stall_en && (stall_ctr % 3 == 0))) begin
                if (rd_req) begin
                    rd_ack  = 1'b1;
                    rd_data = mem[idx({10'd0, bus_addr[23:2]} + 32'(beat))];
                end else begin
                    wr_ack = 1'b1;
                end
                last_ack = (beat == int'(bus_len) - 1);
                beat++;
            end
        end
    end

    // ---------------- compare process ----------------
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    always @(negedge clk) begin : cmp_proc
        burst_t g;
        burst_t e;
        #1;
        if (!rst) begin
            if ((rd_req && !prev_rd) || (wr_req && !prev_wr)) begin
                g = '{wr: wr_req, addr: bus_addr, len: 8'(bus_len)};
                got_bursts.push_back(g);
                chk("bus_size", 32'(bus_size), 32'd2);
                if (exp_bursts.size() == 0) begin
                    chk("burst_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_bursts.pop_front();
                    chk("burst_dir", 32'(g.wr), 32'(e.wr));
                    chk("burst_addr", g.addr, e.addr);
                    chk("burst_len", 32'(g.len), 32'(e.len));
                    chk("burst_inc", 32'(bus_inc), 32'(!e.wr));
                end
            end
            if (wr_req && wr_ack) begin
                got_q.push_back(wdata);
                if (exp_q.size() == 0) chk("wdata_unexpected", wdata, 32'hDEAD_DEAD);
                else                   chk("wdata", wdata, exp_q.pop_front());
            end
            if (prev_wr && !wr_req) chk("fifo_empty_after_wr", 32'(fifo_level), 32'd0);
            if (dmac_irq) begin
                irq_cnt++;
                if (dmac_ack) ack_cnt++;
                chk("clr_with_irq", 32'(tr_clr), 32'd1);
                chk("ack_on_irq", 32'(dmac_ack), 32'(exp_outcome == 0));
                chk("err_on_irq", 32'(st_err), 32'(exp_outcome == 1));
                chk("abort_on_irq", 32'(st_abort), 32'(exp_outcome == 2));
                if (exp_outcome != 2) begin
                    chk("bursts_left", 32'(exp_bursts.size()), 32'd0);
                    chk("words_left", 32'(exp_q.size()), 32'd0);
                end
            end else if (dmac_ack || tr_clr) begin
                chk("pulse_without_irq", {30'd0, dmac_ack, tr_clr}, 32'd0);
            end
        end
        prev_rd = rd_req;
        prev_wr = wr_req;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_obs();
        got_bursts.delete();
        got_q.delete();
        irq_cnt = 0;
        ack_cnt = 0;
    endtask

    task automatic start_run(input logic [31:0] m);
        clear_obs();
        madr = m;
        build_model(m);
        @(negedge clk);
        tr = 1'b1;
    endtask

    // Emulates the register block: TR is cleared once the channel pulses CLR.
    task automatic wait_irq(input int budget, input string name);
        int c = 0;
        while (!dmac_irq && c < budget) begin
            @(negedge clk); #2;
            c++;
        end
        chk(name, 32'(dmac_irq), 32'd1);
        tr = 1'b0;
        @(negedge clk); #2;
        chk({name, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0:       return wr_req;
            1:       return rd_req && (dbg_state == ST_PAY_RD);
            default: return dbg_state == ST_WAIT_REQ;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input int budget, input string name);
        int c = 0;
        while (!cond(sel) && c < budget) begin
            @(negedge clk); #2;
            c++;
        end
        chk(name, 32'(cond(sel)), 32'd1);
    endtask

    function automatic int rd_bursts();
        int cnt = 0;
        foreach (got_bursts[i]) if (!got_bursts[i].wr) cnt++;
        return cnt;
    endfunction

    // ---------------- directed tests ----------------
    initial begin
        int bp_wr;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;

        // reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_ack", 32'(dmac_ack), 32'd0);
        chk("rst_irq", 32'(dmac_irq), 32'd0);
        chk("rst_clr", 32'(tr_clr), 32'd0);
        chk("rst_err", 32'(st_err), 32'd0);
        chk("rst_abort", 32'(st_abort), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_len", 32'(bus_len), 32'd0);
        chk("rst_inc", 32'(bus_inc), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;

        // single node, three payload words
        mem[32'h100 >> 2] = 32'h03FF_FFFF;
        mem[32'h104 >> 2] = 32'hA000_000A;
        mem[32'h108 >> 2] = 32'hB000_000B;
        mem[32'h10C >> 2] = 32'hC000_000C;
        start_run(32'h100);
        wait_irq(200, "t1_irq");
        chk("t1_nbursts", 32'(got_bursts.size()), 32'd3);
        chk("t1_hdr_addr", got_bursts[0].addr, 32'h100);
        chk("t1_pay_addr", got_bursts[1].addr, 32'h104);
        chk("t1_pay_len", 32'(got_bursts[1].len), 32'd3);
        chk("t1_wr_addr", got_bursts[2].addr, 32'h1F80_1810);
        chk("t1_w0", got_q[0], 32'hA000_000A);
        chk("t1_w2", got_q[2], 32'hC000_000C);
        chk("t1_ack_cnt", 32'(ack_cnt), 32'd1);
        chk("t1_irq_cnt", 32'(irq_cnt), 32'd1);

        // burst split: 20 words -> 16 + 4, with slave stalls
        mem[32'h100 >> 2] = 32'h14FF_FFFF;
        for (int i = 0; i < 20; i++) mem[(32'h104 >> 2) + i] = 32'hB000_0000 + 32'(i);
        stall_en = 1'b1;
        start_run(32'h100);
        wait_irq(600, "t2_irq");
        stall_en = 1'b0;
        chk("t2_nbursts", 32'(got_bursts.size()), 32'd5);
        chk("t2_rd0_addr", got_bursts[1].addr, 32'h104);
        chk("t2_rd0_len", 32'(got_bursts[1].len), 32'd16);
        chk("t2_wr0_len", 32'(got_bursts[2].len), 32'd16);
        chk("t2_rd1_addr", got_bursts[3].addr, 32'h144);
        chk("t2_rd1_len", 32'(got_bursts[3].len), 32'd4);
        chk("t2_words", 32'(got_q.size()), 32'd20);
        chk("t2_last_word", got_q[19], 32'hB000_0013);

        // chain with an empty first node
        mem[32'h300 >> 2] = 32'h0000_0200;
        mem[32'h200 >> 2] = 32'h02FF_FFFF;
        mem[32'h204 >> 2] = 32'hC000_0001;
        mem[32'h208 >> 2] = 32'hC000_0002;
        start_run(32'h300);
        wait_irq(300, "t3_irq");
        chk("t3_nbursts", 32'(got_bursts.size()), 32'd4);
        chk("t3_hdr1_addr", got_bursts[1].addr, 32'h200);
        chk("t3_pay_addr", got_bursts[2].addr, 32'h204);
        chk("t3_words", 32'(got_q.size()), 32'd2);
        chk("t3_w1", got_q[1], 32'hC000_0002);
        chk("t3_ack_cnt", 32'(ack_cnt), 32'd1);

        // self-referencing header hits the node limit
        mem[32'h100 >> 2] = 32'h0000_0100;
        start_run(32'h100);
        wait_irq(300, "t4_irq");
        chk("t4_hdr_reads", 32'(rd_bursts()), 32'd4);
        chk("t4_hdr_addr", got_bursts[3].addr, 32'h100);
        chk("t4_writes", 32'(got_q.size()), 32'd0);
        chk("t4_ack_cnt", 32'(ack_cnt), 32'd0);
        chk("t4_irq_cnt", 32'(irq_cnt), 32'd1);
        chk("t4_err_sticky", 32'(st_err), 32'd1);

        // peripheral backpressure, then TR dropped during the first write burst
        mem[32'h100 >> 2] = 32'h14FF_FFFF;
        dmac_req = 1'b0;
        start_run(32'h100);
        exp_outcome = 2;
        wait_cond(2, 200, "t5_reach_wait");
        chk("t5_err_cleared", 32'(st_err), 32'd0);
        bp_wr = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #2;
            if (wr_req) bp_wr++;
        end
        chk("t5_no_write_bp", 32'(bp_wr), 32'd0);
        chk("t5_still_waiting", 32'(dbg_state), 32'(ST_WAIT_REQ));
        dmac_req = 1'b1;
        wait_cond(0, 50, "t5_write_start");
        tr = 1'b0;
        wait_irq(300, "t5_irq");
        chk("t5_words", 32'(got_q.size()), 32'd16);
        chk("t5_abort_sticky", 32'(st_abort), 32'd1);
        chk("t5_ack_cnt", 32'(ack_cnt), 32'd0);
        chk("t5_irq_cnt", 32'(irq_cnt), 32'd1);

        // reset in the middle of a payload read, then a clean restart
        start_run(32'h100);
        wait_cond(1, 200, "t6_in_pay_rd");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #2;
        chk("t6_rd_req", 32'(rd_req), 32'd0);
        chk("t6_wr_req", 32'(wr_req), 32'd0);
        chk("t6_fifo_empty", 32'(fifo_level), 32'd0);
        chk("t6_state", 32'(dbg_state), 32'(ST_IDLE));
        tr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        start_run(32'h300);
        wait_irq(300, "t6_irq");
        chk("t6_words", 32'(got_q.size()), 32'd2);
        chk("t6_w0", got_q[0], 32'hC000_0001);
        chk("t6_ack_cnt", 32'(ack_cnt), 32'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need completion)");
        $fatal(1);
    end

endmodule
